exp_job_scheduler: RTL

- Shares one exponent engine (a^n via repeated multiply; go/done handshake) between two requesters, e.g. the keypad front-end and the LCD refresh path.
- Arbitrates round-robin, latches the winner's operands, clears and launches the engine, and waits for done with a timeout.
- Returns the result, tagged to the owning requester.

---
 rtl/exp_job_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/exp_job_scheduler.sv
// Round-robin scheduler sharing one a^n exponent engine between two requesters.
// Latches the winner's operands, clears and launches the engine, waits for done or timeout.
module exp_job_scheduler #(
  parameter int DW      = 8,
  parameter int RW      = 16,
  parameter int TW      = 8,
  parameter int TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] n0,
  input  logic          req1,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] n1,
  output logic          ack0,
  output logic          ack1,
  output logic          rsp_valid0,
  output logic          rsp_valid1,
  output logic [RW-1:0] rsp_result,
  output logic          rsp_err,
  output logic          busy,
  output logic          eng_clr_n,
  output logic          eng_go,
  output logic [DW-1:0] eng_a,
  output logic [DW-1:0] eng_n,
  input  logic          eng_done,
  input  logic [RW-1:0] eng_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_RESPOND
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;
  logic          r_last_owner;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_eng_a;
  logic [DW-1:0] r_eng_n;
  logic [RW-1:0] r_rsp_result;
  logic          r_rsp_err;
  logic          w_any_req;
  logic          w_grant;
  logic          w_timeout;

  assign w_any_req = req0 | req1;
  // Under contention the requester that was not served last wins; otherwise whoever asks.
  assign w_grant   = (req0 && req1) ? ~r_last_owner : req1;
  assign w_timeout = (r_timer == TIMER_LAST);

  assign eng_a      = r_eng_a;
  assign eng_n      = r_eng_n;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_next     = r_state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    eng_clr_n  = 1'b1;
    eng_go     = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:    if (w_any_req) w_next = S_CLEAR;
      S_CLEAR: begin
        ack0      = ~r_owner;
        ack1      = r_owner;
        eng_clr_n = 1'b0;
        w_next    = S_LAUNCH;
      end
      S_LAUNCH: begin
        eng_go = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT:    if (eng_done || w_timeout) w_next = S_RESPOND;
      S_RESPOND: begin
        rsp_valid0 = ~r_owner;
        rsp_valid1 = r_owner;
        w_next     = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_timer      <= '0;
      r_eng_a      <= '0;
      r_eng_n      <= '0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_eng_a <= w_grant ? a1 : a0;
            r_eng_n <= w_grant ? n1 : n0;
          end
        end
        S_LAUNCH: r_timer <= '0;
        S_WAIT: begin
          // Done is only honoured here, so a sticky done from the previous job cannot leak in.
          if (eng_done) begin
            r_rsp_result <= eng_result;
            r_rsp_err    <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESPOND: r_last_owner <= r_owner;
        default: ;
      endcase
    end
  end

endmodule
